// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier tile.
// Holds the controller state encoding, the default operand width and the counter sizing helper.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // The bit counter must be able to hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_acc_adder.sv
// Single adder of the shift-and-add datapath.
// It takes two WIDTH-bit operands and produces a WIDTH+1-bit result, given as a sum plus a carry out.
module mult_acc_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  assign {carry_o, sum_o} = {1'b0, op_a_i} + {1'b0, op_b_i};

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential radix-2 shift-and-add multiplier with a valid/ready handshake and an unsigned/signed mode.
// Define MULT_EARLY_TERM_EN to leave RUN as soon as the remaining multiplier bits are all zero.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  state_e               state_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   product_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [CW-1:0]        cnt_q;
  logic                 neg_q;
  logic                 inReady_q;
  logic                 outValid_q;
  logic                 busy_q;

  logic [WIDTH-1:0]     aMag;
  logic [WIDTH-1:0]     bMag;
  logic                 negIn;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 carry;
  logic [2*WIDTH-1:0]   accStep_d;
  logic [2*WIDTH-1:0]   accFinal;
  logic [2*WIDTH-1:0]   product_d;
  logic                 runDone;

  // The magnitude of -2^(WIDTH-1) wraps to 2^(WIDTH-1), which still fits as an unsigned value.
  always_comb begin
    aMag  = (signed_mode && a[WIDTH-1]) ? -a : a;
    bMag  = (signed_mode && b[WIDTH-1]) ? -b : b;
    negIn = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
  end

  assign addend = mplier_q[0] ? mcand_q : '0;

  mult_acc_adder #(
    .WIDTH (WIDTH)
  ) u_acc_adder (
    .op_a_i  (acc_q[2*WIDTH-1:WIDTH]),
    .op_b_i  (addend),
    .sum_o   (sum),
    .carry_o (carry)
  );

  assign accStep_d = {carry, sum, acc_q[WIDTH-1:1]};

  // Early exit leaves the accumulator short of its final alignment by the remaining count.
  always_comb begin
`ifdef MULT_EARLY_TERM_EN
    runDone  = (cnt_q == '0) || (mplier_q == '0);
    accFinal = acc_q >> cnt_q;
`else
    runDone  = (cnt_q == '0);
    accFinal = acc_q;
`endif
    product_d = neg_q ? -accFinal : accFinal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      product_q  <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            mcand_q   <= aMag;
            mplier_q  <= bMag;
            neg_q     <= negIn;
            acc_q     <= '0;
            cnt_q     <= CNT_LOAD;
            inReady_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (runDone) begin
            product_q  <= product_d;
            outValid_q <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            acc_q    <= accStep_d;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          inReady_q  <= 1'b1;
          outValid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed corner cases, reset mid-run, backpressure and a random regression.
// Expected products and latencies come from plain integer arithmetic on the operands.
module tb_shift_add_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           signed_mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product),
    .busy        (busy)
  );

  // Keeps the run bounded even if the handshake never completes.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint opValue(input logic [W-1:0] x, input logic sm);
    longint v;
    v = longint'(x);
    if (sm && x[W-1]) v = v - (longint'(1) << W);
    return v;
  endfunction

  function automatic logic [2*W-1:0] refProduct(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
    longint p;
    p = opValue(x, sm) * opValue(y, sm);
    return (2*W)'(p);
  endfunction

  // Edges from the accept edge to the first edge after which out_valid is seen high.
  function automatic int refLatency(input logic [W-1:0] y, input logic sm);
    longint mag;
    int top;
    mag = opValue(y, sm);
    if (mag < 0) mag = -mag;
    top = -1;
    for (int i = 0; i <= W; i++) if (mag[i]) top = i;
`ifdef MULT_EARLY_TERM_EN
    return (top < 0) ? 1 : top + 2;
`else
    return W + 1;
`endif
  endfunction

  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkVal("in_ready_before_accept", in_ready, 1);
    a = x;
    b = y;
    signed_mode = sm;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    signed_mode = 1'($urandom);
    checkVal("busy_after_accept", busy, 1);
    checkVal("in_ready_after_accept", in_ready, 0);
  endtask

  task automatic checkOutput(input string tag, input logic [2*W-1:0] expP, input int expL, input int stall, input bool_hold_check);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    out_ready = 1'b0;
    checkVal({tag, "_latency"}, 64'(lat), 64'(expL));
    checkVal({tag, "_product"}, product, expP);
    for (int s = 0; s < stall; s++) begin
      in_valid = (bool_hold_check != 0);
      @(posedge clk); #1;
      if (bool_hold_check != 0) begin
        checkVal({tag, "_hold_product"}, product, expP);
        checkVal({tag, "_hold_in_ready"}, in_ready, 0);
        checkVal({tag, "_hold_out_valid"}, out_valid, 1);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkVal({tag, "_release_in_ready"}, in_ready, 1);
    checkVal({tag, "_release_out_valid"}, out_valid, 0);
  endtask

  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           sm;
    logic [2*W-1:0] p;
  } dirCase_t;

  dirCase_t dirCases[6];

  initial begin
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic         rs;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    signed_mode = 1'b0;

    dirCases[0] = '{8'd13,  8'd11,  1'b0, 16'h008F};
    dirCases[1] = '{8'd255, 8'd255, 1'b0, 16'hFE01};
    dirCases[2] = '{8'hFD,  8'd5,   1'b1, 16'hFFF1};
    dirCases[3] = '{8'h80,  8'h80,  1'b1, 16'h4000};
    dirCases[4] = '{8'h80,  8'h00,  1'b1, 16'h0000};
    dirCases[5] = '{8'h00,  8'hFF,  1'b1, 16'h0000};

    #12;
    checkVal("reset_in_ready", in_ready, 1);
    checkVal("reset_out_valid", out_valid, 0);
    checkVal("reset_busy", busy, 0);
    checkVal("reset_product", product, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkVal("post_reset_in_ready", in_ready, 1);
    checkVal("post_reset_busy", busy, 0);

    $display("[TB] directed corner cases");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(dirCases[i].x, dirCases[i].y, dirCases[i].sm);
      checkOutput($sformatf("dir%0d", i), dirCases[i].p, refLatency(dirCases[i].y, dirCases[i].sm), 1, 0);
    end

    $display("[TB] backpressure for 20 cycles with in_valid offered");
    applyStimulus(8'd13, 8'd11, 1'b0);
    checkOutput("backpressure", 16'h008F, refLatency(8'd11, 1'b0), 20, 1);

    $display("[TB] reset in the middle of RUN");
    applyStimulus(8'd100, 8'd200, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checkVal("midreset_out_valid", out_valid, 0);
    checkVal("midreset_busy", busy, 0);
    checkVal("midreset_in_ready", in_ready, 1);
    checkVal("midreset_product", product, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(8'd7, 8'd6, 1'b0);
    checkOutput("after_reset", 16'd42, refLatency(8'd6, 1'b0), 0, 0);

    $display("[TB] random regression");
    for (int i = 0; i < 2000; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      rs = 1'($urandom);
      if ($urandom_range(0, 15) == 0) ry = '0;
      if ($urandom_range(0, 15) == 0) rx = 8'h80;
      applyStimulus(rx, ry, rs);
      checkOutput("random", refProduct(rx, ry, rs), refLatency(ry, rs), $urandom_range(0, 3), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
